// File: rtl/mem_burst_if.sv
// mem_burst_if: read/write burst bus between a requester (master) and the memory responder (slave)
interface mem_burst_if;
    logic        rd_req_valid;
    logic [31:0] rd_req_addr;
    logic [7:0]  rd_req_len;
    logic        rd_req_ready;
    logic        rd_rsp_valid;
    logic [31:0] rd_rsp_data;
    logic        rd_rsp_last;
    logic        rd_rsp_ready;
    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic [7:0]  wr_req_len;
    logic        wr_req_ready;
    logic        wr_data_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_data_strb;
    logic        wr_data_last;
    logic        wr_data_ready;
    logic        err_len;
    modport master (
        output rd_req_valid, rd_req_addr, rd_req_len, rd_rsp_ready,
        output wr_req_valid, wr_req_addr, wr_req_len,
        output wr_data_valid, wr_data, wr_data_strb, wr_data_last,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_last,
        input  wr_req_ready, wr_data_ready, err_len
    );
    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_len, rd_rsp_ready,
        input  wr_req_valid, wr_req_addr, wr_req_len,
        input  wr_data_valid, wr_data, wr_data_strb, wr_data_last,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_last,
        output wr_req_ready, wr_data_ready, err_len
    );
endinterface

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: single-outstanding burst memory with programmable read latency and byte-strobed writes
module mem_burst_responder #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input logic       clk,
    input logic       rst,
    mem_burst_if.slave bus
);
    localparam int S_IDLE = 0, S_RD_WAIT = 1, S_RD_BURST = 2, S_WR_DATA = 3;
    localparam logic [3:0] IDLE = 4'b0001, RD_WAIT = 4'b0010, RD_BURST = 4'b0100, WR_DATA = 4'b1000;
    localparam logic [7:0] WAIT_END = 8'(RD_LAT > 0 ? RD_LAT - 1 : 0);

    logic [31:0]       mem [2**ADDR_W];
    logic [3:0]        st, nxt;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        cnt, len, wcnt;
    logic              err_q, at_len, rd_acc, wr_acc, rd_hs, wr_hs, wr_end;
    logic              unused_addr;

    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= nxt;

    always_comb begin
        at_len = cnt == len;
        rd_acc = bus.rd_req_valid & bus.rd_req_ready;
        wr_acc = bus.wr_req_valid & bus.wr_req_ready;
        rd_hs  = bus.rd_rsp_valid & bus.rd_rsp_ready;
        wr_hs  = bus.wr_data_valid & bus.wr_data_ready;
        wr_end = wr_hs & (bus.wr_data_last | at_len);
        unused_addr = ^{bus.rd_req_addr[31:ADDR_W+2], bus.rd_req_addr[1:0],
                        bus.wr_req_addr[31:ADDR_W+2], bus.wr_req_addr[1:0]};
    end

    always_comb begin
        nxt = st;
        if (st[S_IDLE]) nxt = rd_acc ? (RD_LAT == 0 ? RD_BURST : RD_WAIT) : wr_acc ? WR_DATA : IDLE;
        if (st[S_RD_WAIT] && wcnt == WAIT_END) nxt = RD_BURST;
        if (st[S_RD_BURST] && rd_hs && at_len) nxt = IDLE;
        if (st[S_WR_DATA] && wr_end) nxt = IDLE;
    end

    // Ready outputs are gated by rst so they read 0 for the whole reset, not just after the first edge
    always_comb begin
        bus.rd_req_ready  = st[S_IDLE] & ~rst;
        bus.wr_req_ready  = st[S_IDLE] & ~rst & ~bus.rd_req_valid;
        bus.rd_rsp_valid  = st[S_RD_BURST];
        bus.rd_rsp_last   = st[S_RD_BURST] & at_len;
        bus.rd_rsp_data   = mem[ptr];
        bus.wr_data_ready = st[S_WR_DATA];
        bus.err_len       = err_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr   <= '0;
            cnt   <= '0;
            len   <= '0;
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= wr_end & (bus.wr_data_last != at_len);
            wcnt  <= st[S_RD_WAIT] ? wcnt + 8'd1 : 8'd0;
            if (rd_acc) begin
                ptr <= bus.rd_req_addr[ADDR_W+1:2];
                cnt <= '0;
                len <= bus.rd_req_len;
            end else if (wr_acc) begin
                ptr <= bus.wr_req_addr[ADDR_W+1:2];
                cnt <= '0;
                len <= bus.wr_req_len;
            end else if (rd_hs | wr_hs) begin
                ptr <= ptr + 1'b1;
                cnt <= cnt + 8'd1;
            end
        end

    // Storage is deliberately not reset; rst only blocks writes by forcing the FSM out of WR_DATA
    always_ff @(posedge clk)
        if (wr_hs)
            for (int b = 0; b < 4; b++)
                if (bus.wr_data_strb[b]) mem[ptr][8*b +: 8] <= bus.wr_data[8*b +: 8];
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: table-driven strobe vectors plus scoreboarded burst sequences
module tb_mem_burst_responder;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;

    typedef struct {logic [31:0] data; logic last;} beat_t;
    typedef struct {logic [31:0] old_w; logic [31:0] new_w; logic [3:0] strb; logic [31:0] exp;} strb_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit stall_mode = 1'b0;
    int errors = 0;
    int checks = 0;
    beat_t exp_q[$];
    logic [31:0] model [256];
    strb_vec_t tbl [6];

    mem_burst_if bus();
    mem_burst_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    task automatic idle_inputs();
        bus.rd_req_valid  = 1'b0;
        bus.wr_req_valid  = 1'b0;
        bus.wr_data_valid = 1'b0;
        bus.wr_data_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_req_ready"}, bus.rd_req_ready, 0);
        chk({tag, "_wr_req_ready"}, bus.wr_req_ready, 0);
        chk({tag, "_rd_rsp_valid"}, bus.rd_rsp_valid, 0);
        chk({tag, "_rd_rsp_last"}, bus.rd_rsp_last, 0);
        chk({tag, "_wr_data_ready"}, bus.wr_data_ready, 0);
        chk({tag, "_err_len"}, bus.err_len, 0);
    endtask

    // Read-beat monitor: drives rd_rsp_ready and compares every valid cycle (stalled or not) to the queue head
    initial begin
        bus.rd_rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.rd_rsp_ready = stall_mode ? ~bus.rd_rsp_ready : 1'b1;
            #2;
            if (bus.rd_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected_beat: data %h with nothing expected", bus.rd_rsp_data);
                end else begin
                    chk("rd_data", bus.rd_rsp_data, exp_q[0].data);
                    chk("rd_last", bus.rd_rsp_last, exp_q[0].last);
                    if (bus.rd_rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input int last_beat,
                               input logic [31:0] base, input logic [3:0] strb);
        logic [7:0] w;
        bit acc = 1'b0;
        bit term = 1'b0;
        @(negedge clk);
        bus.wr_req_valid = 1'b1;
        bus.wr_req_addr  = addr;
        bus.wr_req_len   = len;
        for (int t = 0; t < 300 && !acc; t++) begin
            #1;
            acc = bus.wr_req_ready;
            @(negedge clk);
        end
        bus.wr_req_valid = 1'b0;
        if (!acc) begin
            fail_now("wr_req_accept");
            return;
        end
        w = addr[ADDR_W+1:2];
        for (int i = 0; i < 256 && !term; i++) begin
            bus.wr_data_valid = 1'b1;
            bus.wr_data       = base + i;
            bus.wr_data_strb  = strb;
            bus.wr_data_last  = (i == last_beat);
            #1;
            chk("wr_data_ready", bus.wr_data_ready, 1);
            chk("err_len_in_burst", bus.err_len, 0);
            model[w] = merge(model[w], base + i, strb);
            term = (i == last_beat) || (i == int'(len));
            w++;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("err_len_pulse", bus.err_len, {31'd0, last_beat != int'(len)});
        chk("idle_after_wr", bus.rd_req_ready, 1);
        @(negedge clk);
        #1;
        chk("err_len_clear", bus.err_len, 0);
    endtask

    task automatic read_req(input logic [31:0] addr, input logic [7:0] len, input bit timed);
        bit acc = 1'b0;
        int k = 1;
        int c = 0;
        @(negedge clk);
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = addr;
        bus.rd_req_len   = len;
        for (int t = 0; t < 300 && !acc; t++) begin
            #1;
            acc = bus.rd_req_ready;
            @(negedge clk);
        end
        bus.rd_req_valid = 1'b0;
        if (!acc) begin
            fail_now("rd_req_accept");
            exp_q.delete();
            return;
        end
        #3;
        while (!bus.rd_rsp_valid && k < 50) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (timed) chk("rd_first_latency", k, RD_LAT + 1);
        while (exp_q.size() > 0 && c < 2000) begin
            @(negedge clk);
            #3;
            c++;
        end
        if (exp_q.size() > 0) begin
            fail_now("rd_burst_drain");
            exp_q.delete();
        end
        if (timed) chk("rd_burst_cycles", c, int'(len));
        @(negedge clk);
        #3;
        chk("rd_valid_done", bus.rd_rsp_valid, 0);
        chk("idle_after_rd", bus.rd_req_ready, 1);
    endtask

    task automatic push_read(input logic [31:0] addr, input logic [7:0] len);
        logic [7:0] w = addr[ADDR_W+1:2];
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back('{data: model[w], last: (i == int'(len))});
            w++;
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input bit timed);
        push_read(addr, len);
        read_req(addr, len, timed);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int n;
        tbl[0] = '{32'hAABBCCDD, 32'h11223344, 4'b0101, 32'hAA22CC44};
        tbl[1] = '{32'hAABBCCDD, 32'h11223344, 4'b1010, 32'h11BB33DD};
        tbl[2] = '{32'hAABBCCDD, 32'h11223344, 4'b0000, 32'hAABBCCDD};
        tbl[3] = '{32'hAABBCCDD, 32'h11223344, 4'b1111, 32'h11223344};
        tbl[4] = '{32'hAABBCCDD, 32'h11223344, 4'b1000, 32'h11BBCCDD};
        tbl[5] = '{32'h01020304, 32'hF0E0D0C0, 4'b0011, 32'h0102D0C0};
        idle_inputs();
        bus.rd_req_addr  = '0;
        bus.rd_req_len   = '0;
        bus.wr_req_addr  = '0;
        bus.wr_req_len   = '0;
        bus.wr_data      = '0;
        bus.wr_data_strb = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_rd_ready", bus.rd_req_ready, 1);
        chk("rst_release_wr_ready", bus.wr_req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            write_burst(32'h10 + 4 * i, 8'd0, 0, tbl[i].old_w, 4'hF);
            write_burst(32'h10 + 4 * i, 8'd0, 0, tbl[i].new_w, tbl[i].strb);
            exp_q.push_back('{data: tbl[i].exp, last: 1'b1});
            read_req(32'h10 + 4 * i, 8'd0, 1'b1);
        end

        write_burst(32'h80, 8'd7, 7, 32'hA0, 4'hF);
        read_burst(32'h80, 8'd7, 1'b1);
        stall_mode = 1'b1;
        read_burst(32'h80, 8'd7, 1'b0);
        stall_mode = 1'b0;

        // Simultaneous requests: read wins, write must stay held off for the whole read burst
        push_read(32'h80, 8'd7);
        @(negedge clk);
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = 32'h80;
        bus.rd_req_len   = 8'd7;
        bus.wr_req_valid = 1'b1;
        bus.wr_req_addr  = 32'h100;
        bus.wr_req_len   = 8'd1;
        #1;
        chk("prio_rd_ready", bus.rd_req_ready, 1);
        chk("prio_wr_ready", bus.wr_req_ready, 0);
        @(negedge clk);
        bus.rd_req_valid = 1'b0;
        #3;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            chk("wr_held_off", bus.wr_req_ready, 0);
            @(negedge clk);
            #3;
            n++;
        end
        if (exp_q.size() > 0) begin
            fail_now("prio_read_drain");
            exp_q.delete();
        end
        write_burst(32'h100, 8'd1, 1, 32'hC0, 4'hF);
        read_burst(32'h100, 8'd1, 1'b1);

        write_burst(32'h140, 8'd3, 3, 32'h500, 4'hF);
        write_burst(32'h140, 8'd3, 1, 32'h600, 4'hF);
        read_burst(32'h140, 8'd3, 1'b1);
        write_burst(32'h180, 8'd1, 5, 32'h900, 4'hF);
        read_burst(32'h180, 8'd1, 1'b1);
        write_burst(32'h3FC, 8'd1, 1, 32'hF00, 4'hF);
        read_burst(32'h123407FF, 8'd1, 1'b1);

        write_burst(32'h0, 8'd255, 255, 32'h1000, 4'hF);
        read_burst(32'h400, 8'd255, 1'b1);

        // Reset in the middle of an 8-beat write: beats 0-2 land, beat 3 onward must not
        write_burst(32'h180, 8'd7, 7, 32'h700, 4'hF);
        @(negedge clk);
        bus.wr_req_valid = 1'b1;
        bus.wr_req_addr  = 32'h180;
        bus.wr_req_len   = 8'd7;
        #1;
        chk("rst_wr_accept", bus.wr_req_ready, 1);
        @(negedge clk);
        bus.wr_req_valid = 1'b0;
        w = 8'h60;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data_valid = 1'b1;
            bus.wr_data       = 32'h800 + i;
            bus.wr_data_strb  = 4'hF;
            #1;
            chk("rst_wr_beat_ready", bus.wr_data_ready, 1);
            model[w] = 32'h800 + i;
            w++;
            @(negedge clk);
        end
        bus.wr_data = 32'h803;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_burst_rst");
        repeat (2) @(negedge clk);
        #1;
        chk("rst_held_wr_data_ready", bus.wr_data_ready, 0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_rd_ready2", bus.rd_req_ready, 1);
        read_burst(32'h180, 8'd7, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-002 Parameter ADDR_W, default 8, SHALL set the word-index width; storage depth SHALL be 2^ADDR_W 32-bit words.
REQ-003 Parameter RD_LAT, default 2, SHALL set the number of idle cycles between read-request acceptance and the first read beat (0 allowed).
REQ-004 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async reset, active-high
- rd_req_valid  in  1  read request valid
- rd_req_addr  in  32  read byte address; bits [1:0] ignored
- rd_req_len  in  8  read beats minus one
- rd_req_ready  out  1  read request accepted
- rd_rsp_valid  out  1  read beat valid
- rd_rsp_data  out  32  read beat data
- rd_rsp_last  out  1  final read beat
- rd_rsp_ready  in  1  requester accepts read beat
- wr_req_valid  in  1  write request valid
- wr_req_addr  in  32  write byte address; bits [1:0] ignored
- wr_req_len  in  8  write beats minus one
- wr_req_ready  out  1  write request accepted
- wr_data_valid  in  1  write beat valid
- wr_data  in  32  write beat data
- wr_data_strb  in  4  byte enables; bit n enables byte n
- wr_data_last  in  1  requester marks final write beat
- wr_data_ready  out  1  write beat accepted
- err_len  out  1  one-cycle pulse on write burst length mismatch

Function
REQ-005 The FSM SHALL have the states IDLE, RD_WAIT, RD_BURST and WR_DATA, one-hot encoded; only one transaction SHALL be in flight at a time.
REQ-006 In IDLE, rd_req_ready SHALL be 1, and wr_req_ready SHALL be ~rd_req_valid; reads take priority when both requests are valid in the same cycle.
REQ-007 On read acceptance, the block SHALL latch ptr=addr[ADDR_W+1:2], cnt=0 and len, then go to RD_WAIT (RD_LAT>0) or directly to RD_BURST (RD_LAT=0).
REQ-008 RD_WAIT SHALL last exactly RD_LAT cycles, then go to RD_BURST.
REQ-009 In RD_BURST:
- rd_rsp_valid SHALL be 1 and rd_rsp_data SHALL be mem[ptr].
- rd_rsp_last SHALL be (cnt==len).
- Data and last SHALL hold stable while rd_rsp_ready=0.
- Each handshake SHALL increment ptr and cnt.
- The handshake with last=1 SHALL return the FSM to IDLE.
REQ-010 On write acceptance, the block SHALL latch ptr, cnt=0 and len, then go to WR_DATA, where wr_data_ready SHALL be 1.
REQ-011 Each WR_DATA handshake SHALL write mem[ptr] byte n only where wr_data_strb[n]=1, then increment ptr and cnt.
REQ-012 WR_DATA SHALL end at the first handshake where wr_data_last=1 or cnt==len, returning to IDLE the next cycle.
REQ-013 When wr_data_last differs from (cnt==len) on that terminating beat, err_len SHALL pulse for exactly one cycle; the terminating beat SHALL still be written.
REQ-014 ptr SHALL wrap modulo 2^ADDR_W, and address bits above ADDR_W+1 SHALL be ignored.
REQ-015 Beat count SHALL be len+1; len=255 yields 256 beats.
REQ-016 Requests presented outside IDLE SHALL be held off (ready=0) and SHALL NOT be lost or altered.

Reset
REQ-017 While rst=1, all of the following SHALL be 0: rd_req_ready, wr_req_ready, rd_rsp_valid, rd_rsp_last, wr_data_ready and err_len; the FSM SHALL be in IDLE.
REQ-018 Reset asserted mid-burst SHALL abort the burst with no further memory writes; memory contents SHALL NOT be cleared by reset.
REQ-019 In the first cycle after rst deasserts, rd_req_ready SHALL be 1.

Verification
REQ-020 Preload words 0x20..0x27 with 0xA0..0xA7; read addr=0x80, len=7, RD_LAT=2, rd_rsp_ready=1 -> first valid 3 cycles after acceptance, data 0xA0..0xA7 on consecutive cycles, last only on 0xA7.
REQ-021 Same read with rd_rsp_ready toggling 1/0 -> each beat held stable while stalled, 8 beats total, order unchanged.
REQ-022 Write addr=0x10, len=0, data=0x11223344, strb=4'b0101 over word 0xAABBCCDD -> a read of 0x10 returns 0xAA22CC44.
REQ-023 rd_req_valid and wr_req_valid asserted in the same IDLE cycle -> read accepted, wr_req_ready=0 until the read burst completes, then the write is accepted.
REQ-024 Write len=3 with wr_data_last on beat 1 -> 2 words written, err_len one pulse, IDLE next cycle; read at word index 2^ADDR_W-1 with len=1 -> second beat returns word 0.
REQ-025 Assert rst during beat 3 of an 8-beat write -> outputs 0 immediately, beats 0-2 retained, later beats not written, rd_req_ready=1 after release.
